// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired CPU control sequencer.
//   - opcode constants (IR[31:27])
//   - ALU operation codes driven on alu_op
//   - 4-bit state encoding (RST, T0-T7, HALT)
//   - opcode-class type and decode helper
//   - packed bundle of every datapath strobe
package cpu_ctrl_pkg;

    // Opcodes
    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_ADD  = 5'b00011;
    localparam logic [4:0] OPC_SUB  = 5'b00100;
    localparam logic [4:0] OPC_AND  = 5'b00101;
    localparam logic [4:0] OPC_OR   = 5'b00110;
    localparam logic [4:0] OPC_ROR  = 5'b00111;
    localparam logic [4:0] OPC_ROL  = 5'b01000;
    localparam logic [4:0] OPC_SHR  = 5'b01001;
    localparam logic [4:0] OPC_SHRA = 5'b01010;
    localparam logic [4:0] OPC_SHL  = 5'b01011;
    localparam logic [4:0] OPC_ADDI = 5'b01100;
    localparam logic [4:0] OPC_ANDI = 5'b01101;
    localparam logic [4:0] OPC_ORI  = 5'b01110;
    localparam logic [4:0] OPC_BR   = 5'b10011;
    localparam logic [4:0] OPC_IN   = 5'b10110;
    localparam logic [4:0] OPC_OUT  = 5'b10111;
    localparam logic [4:0] OPC_NOP  = 5'b11010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_ROR  = 4'd4;
    localparam logic [3:0] ALU_ROL  = 4'd5;
    localparam logic [3:0] ALU_SHR  = 4'd6;
    localparam logic [3:0] ALU_SHRA = 4'd7;
    localparam logic [3:0] ALU_SHL  = 4'd8;

    // Sequencer states
    localparam logic [3:0] ST_RST  = 4'd0;
    localparam logic [3:0] ST_T0   = 4'd1;
    localparam logic [3:0] ST_T1   = 4'd2;
    localparam logic [3:0] ST_T2   = 4'd3;
    localparam logic [3:0] ST_T3   = 4'd4;
    localparam logic [3:0] ST_T4   = 4'd5;
    localparam logic [3:0] ST_T5   = 4'd6;
    localparam logic [3:0] ST_T6   = 4'd7;
    localparam logic [3:0] ST_T7   = 4'd8;
    localparam logic [3:0] ST_HALT = 4'd9;

    typedef enum logic [3:0] {
        CLS_LOAD,
        CLS_LDI,
        CLS_STORE,
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_BR,
        CLS_IN,
        CLS_OUT,
        CLS_NOP,
        CLS_HLT,
        CLS_ILL
    } opc_class_e;

    typedef struct packed {
        logic       pc_out;
        logic       mar_in;
        logic       mdr_in;
        logic       mdr_out;
        logic       read;
        logic       ram_rd;
        logic       ram_in;
        logic       ir_in;
        logic       inc_pc;
        logic       pc_in;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       r_in;
        logic       r_out;
        logic       ba_out;
        logic       c_out;
        logic       y_in;
        logic       z_in;
        logic       zlow_out;
        logic       con_in;
        logic       inport_out;
        logic       outport_in;
        logic [3:0] alu_op;
        logic       run;
        logic       illegal;
    } ctrl_t;

    function automatic opc_class_e decode_class(input logic [4:0] opc);
        opc_class_e cls;
        cls = CLS_ILL;
        if (opc == OPC_LD) begin
            cls = CLS_LOAD;
        end else if (opc == OPC_LDI) begin
            cls = CLS_LDI;
        end else if (opc == OPC_ST) begin
            cls = CLS_STORE;
        end else if (opc >= OPC_ADD && opc <= OPC_SHL) begin
            cls = CLS_ALU_R;
        end else if (opc >= OPC_ADDI && opc <= OPC_ORI) begin
            cls = CLS_ALU_I;
        end else if (opc == OPC_BR) begin
            cls = CLS_BR;
        end else if (opc == OPC_IN) begin
            cls = CLS_IN;
        end else if (opc == OPC_OUT) begin
            cls = CLS_OUT;
        end else if (opc == OPC_NOP) begin
            cls = CLS_NOP;
        end else if (opc == OPC_HALT) begin
            cls = CLS_HLT;
        end
        return cls;
    endfunction

    // ALU op used in T4 of register and immediate ALU instructions.
    function automatic logic [3:0] alu_op_for(input logic [4:0] opc);
        logic [3:0] op;
        op = ALU_ADD;
        if (opc >= OPC_ADD && opc <= OPC_SHL) begin
            // R-type opcodes are contiguous and ordered like the ALU codes.
            op = 4'(opc - OPC_ADD);
        end else if (opc == OPC_ANDI) begin
            op = ALU_AND;
        end else if (opc == OPC_ORI) begin
            op = ALU_OR;
        end
        return op;
    endfunction

endpackage

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for CPU_datapath.
// Runs fetch (T0-T2) then a per-opcode-class execute sequence (T3-T7).
// Ports:
//   clk, rst        - rising-edge clock, synchronous active-high reset
//   opcode          - IR[31:27], captured at the end of T2
//   con_ff          - branch condition flag, captured at the end of T5
//   stop            - halt request sampled at the instruction-end edge
//   PCout..PCin     - fetch / memory / PC strobes
//   Gra..Cout       - register-select and immediate strobes
//   Yin..OutPortin  - ALU / IO strobes
//   alu_op          - ALU operation for the Z register load
//   run             - low only in HALT
//   illegal         - one-cycle pulse in T3 on an undefined opcode
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 4,
    parameter int OPC_W    = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPC_W-1:0]    opcode,
    input  logic                con_ff,
    input  logic                stop,
    output logic                PCout,
    output logic                MARin,
    output logic                MDRin,
    output logic                MDRout,
    output logic                Read,
    output logic                RAMrd,
    output logic                RAMin,
    output logic                IRin,
    output logic                IncPC,
    output logic                PCin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                BAout,
    output logic                Cout,
    output logic                Yin,
    output logic                ZIn,
    output logic                Zlowout,
    output logic                CONin,
    output logic                InPortout,
    output logic                OutPortin,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic                run,
    output logic                illegal
);

    logic [3:0] state_q, state_d;
    logic [4:0] opc_q, opc_d;
    logic       con_q, con_d;
    opc_class_e cls;
    logic [3:0] instr_end;
    ctrl_t      ctrl;

    assign cls       = decode_class(opc_q);
    assign instr_end = stop ? ST_HALT : ST_T0;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        con_d   = con_q;
        case (state_q)
            ST_RST: state_d = ST_T0;
            ST_T0:  state_d = ST_T1;
            ST_T1:  state_d = ST_T2;
            ST_T2: begin
                state_d = ST_T3;
                opc_d   = 5'(opcode);
            end
            ST_T3: begin
                unique case (cls)
                    CLS_HLT:                           state_d = ST_HALT;
                    CLS_IN, CLS_OUT, CLS_NOP, CLS_ILL: state_d = instr_end;
                    default:                           state_d = ST_T4;
                endcase
            end
            ST_T4:  state_d = ST_T5;
            ST_T5: begin
                // Latch the flag so the T6 branch decision stays a pure state decode.
                con_d = con_ff;
                unique case (cls)
                    CLS_LDI, CLS_ALU_R, CLS_ALU_I: state_d = instr_end;
                    default:                       state_d = ST_T6;
                endcase
            end
            ST_T6:  state_d = (cls == CLS_BR) ? instr_end : ST_T7;
            ST_T7:  state_d = instr_end;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RST;
            opc_q   <= 5'd0;
            con_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            con_q   <= con_d;
        end
    end

    // Output decode from state and latched opcode only
    always_comb begin
        ctrl     = '0;
        ctrl.run = 1'b1;
        case (state_q)
            ST_T0: begin
                ctrl.pc_out = 1'b1;
                ctrl.mar_in = 1'b1;
                ctrl.inc_pc = 1'b1;
                ctrl.ram_rd = 1'b1;
            end
            ST_T1: begin
                ctrl.read   = 1'b1;
                ctrl.mdr_in = 1'b1;
                ctrl.ram_rd = 1'b1;
            end
            ST_T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                unique case (cls)
                    CLS_LOAD, CLS_LDI, CLS_STORE: begin
                        ctrl.grb    = 1'b1;
                        ctrl.ba_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    CLS_ALU_R, CLS_ALU_I: begin
                        ctrl.grb   = 1'b1;
                        ctrl.r_out = 1'b1;
                        ctrl.y_in  = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.con_in = 1'b1;
                    end
                    CLS_IN: begin
                        ctrl.inport_out = 1'b1;
                        ctrl.gra        = 1'b1;
                        ctrl.r_in       = 1'b1;
                    end
                    CLS_OUT: begin
                        ctrl.gra        = 1'b1;
                        ctrl.r_out      = 1'b1;
                        ctrl.outport_in = 1'b1;
                    end
                    CLS_ILL: ctrl.illegal = 1'b1;
                    default: ;
                endcase
            end
            ST_T4: begin
                unique case (cls)
                    CLS_LOAD, CLS_LDI, CLS_STORE: begin
                        ctrl.c_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = ALU_ADD;
                    end
                    CLS_ALU_R: begin
                        ctrl.grc    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = alu_op_for(opc_q);
                    end
                    CLS_ALU_I: begin
                        ctrl.c_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = alu_op_for(opc_q);
                    end
                    CLS_BR: begin
                        ctrl.pc_out = 1'b1;
                        ctrl.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                unique case (cls)
                    CLS_LOAD, CLS_STORE: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.mar_in   = 1'b1;
                    end
                    CLS_LDI, CLS_ALU_R, CLS_ALU_I: begin
                        ctrl.zlow_out = 1'b1;
                        ctrl.gra      = 1'b1;
                        ctrl.r_in     = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl.c_out  = 1'b1;
                        ctrl.z_in   = 1'b1;
                        ctrl.alu_op = ALU_ADD;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                unique case (cls)
                    CLS_LOAD: begin
                        ctrl.read   = 1'b1;
                        ctrl.mdr_in = 1'b1;
                        ctrl.ram_rd = 1'b1;
                    end
                    CLS_STORE: begin
                        ctrl.gra    = 1'b1;
                        ctrl.r_out  = 1'b1;
                        ctrl.mdr_in = 1'b1;
                    end
                    CLS_BR: begin
                        ctrl.zlow_out = con_q;
                        ctrl.pc_in    = con_q;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                unique case (cls)
                    CLS_LOAD: begin
                        ctrl.mdr_out = 1'b1;
                        ctrl.gra     = 1'b1;
                        ctrl.r_in    = 1'b1;
                    end
                    CLS_STORE: ctrl.ram_in = 1'b1;
                    default: ;
                endcase
            end
            ST_HALT: ctrl.run = 1'b0;
            default: ;
        endcase
    end

    assign PCout     = ctrl.pc_out;
    assign MARin     = ctrl.mar_in;
    assign MDRin     = ctrl.mdr_in;
    assign MDRout    = ctrl.mdr_out;
    assign Read      = ctrl.read;
    assign RAMrd     = ctrl.ram_rd;
    assign RAMin     = ctrl.ram_in;
    assign IRin      = ctrl.ir_in;
    assign IncPC     = ctrl.inc_pc;
    assign PCin      = ctrl.pc_in;
    assign Gra       = ctrl.gra;
    assign Grb       = ctrl.grb;
    assign Grc       = ctrl.grc;
    assign Rin       = ctrl.r_in;
    assign Rout      = ctrl.r_out;
    assign BAout     = ctrl.ba_out;
    assign Cout      = ctrl.c_out;
    assign Yin       = ctrl.y_in;
    assign ZIn       = ctrl.z_in;
    assign Zlowout   = ctrl.zlow_out;
    assign CONin     = ctrl.con_in;
    assign InPortout = ctrl.inport_out;
    assign OutPortin = ctrl.outport_in;
    assign alu_op    = ALU_OP_W'(ctrl.alu_op);
    assign run       = ctrl.run;
    assign illegal   = ctrl.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed scenarios then random instruction streams,
// each cycle compared against a per-instruction strobe table built from the
// opcode map, plus a bus-driver exclusivity check.
module tb_control_unit;

    logic       clk;
    logic       rst;
    logic [4:0] opcode;
    logic       con_ff;
    logic       stop;
    logic PCout, MARin, MDRin, MDRout, Read, RAMrd, RAMin, IRin, IncPC, PCin;
    logic Gra, Grb, Grc, Rin, Rout, BAout, Cout;
    logic Yin, ZIn, Zlowout, CONin, InPortout, OutPortin;
    logic [3:0] alu_op;
    logic run, illegal;

    int n_cmp  = 0;
    int n_fail = 0;

    control_unit #(.ALU_OP_W(4), .OPC_W(5)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .con_ff(con_ff), .stop(stop),
        .PCout(PCout), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .Read(Read),
        .RAMrd(RAMrd), .RAMin(RAMin), .IRin(IRin), .IncPC(IncPC), .PCin(PCin),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .Cout(Cout), .Yin(Yin), .ZIn(ZIn), .Zlowout(Zlowout), .CONin(CONin),
        .InPortout(InPortout), .OutPortin(OutPortin), .alu_op(alu_op), .run(run),
        .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observation vector: 23 strobes, alu_op[5:2], run[1], illegal[0]
    logic [28:0] obs;
    assign obs = {PCout, MARin, MDRin, MDRout, Read, RAMrd, RAMin, IRin, IncPC, PCin,
                  Gra, Grb, Grc, Rin, Rout, BAout, Cout, Yin, ZIn, Zlowout, CONin,
                  InPortout, OutPortin, alu_op, run, illegal};

    localparam logic [28:0] PCO = 29'd1 << 28;
    localparam logic [28:0] MAR = 29'd1 << 27;
    localparam logic [28:0] MDI = 29'd1 << 26;
    localparam logic [28:0] MDO = 29'd1 << 25;
    localparam logic [28:0] RD  = 29'd1 << 24;
    localparam logic [28:0] RRD = 29'd1 << 23;
    localparam logic [28:0] RWR = 29'd1 << 22;
    localparam logic [28:0] IRI = 29'd1 << 21;
    localparam logic [28:0] INC = 29'd1 << 20;
    localparam logic [28:0] PCI = 29'd1 << 19;
    localparam logic [28:0] GRA = 29'd1 << 18;
    localparam logic [28:0] GRB = 29'd1 << 17;
    localparam logic [28:0] GRC = 29'd1 << 16;
    localparam logic [28:0] RIN = 29'd1 << 15;
    localparam logic [28:0] ROU = 29'd1 << 14;
    localparam logic [28:0] BAO = 29'd1 << 13;
    localparam logic [28:0] CO  = 29'd1 << 12;
    localparam logic [28:0] YIN = 29'd1 << 11;
    localparam logic [28:0] ZIN = 29'd1 << 10;
    localparam logic [28:0] ZLO = 29'd1 << 9;
    localparam logic [28:0] CON = 29'd1 << 8;
    localparam logic [28:0] INP = 29'd1 << 7;
    localparam logic [28:0] OUP = 29'd1 << 6;
    localparam logic [28:0] RUN = 29'd1 << 1;
    localparam logic [28:0] ILL = 29'd1;

    function automatic logic [28:0] alu(input int code);
        return 29'(code) << 2;
    endfunction

    logic [28:0] exp_q[$];

    // Expected per-cycle outputs of one instruction, T0 onward.
    task automatic build_model(input logic [4:0] opc, input bit con, output bit halts);
        int v;
        logic [28:0] steps[$];
        v = int'(opc);
        halts = 1'b0;
        steps = '{PCO | MAR | INC | RRD, RD | MDI | RRD, MDO | IRI};
        if (v <= 2) begin
            steps.push_back(GRB | BAO | YIN);
            steps.push_back(CO | ZIN | alu(0));
            if (v == 1) begin
                steps.push_back(ZLO | GRA | RIN);
            end else begin
                steps.push_back(ZLO | MAR);
                if (v == 0) begin
                    steps.push_back(RD | MDI | RRD);
                    steps.push_back(MDO | GRA | RIN);
                end else begin
                    steps.push_back(GRA | ROU | MDI);
                    steps.push_back(RWR);
                end
            end
        end else if (v <= 11) begin
            steps.push_back(GRB | ROU | YIN);
            steps.push_back(GRC | ROU | ZIN | alu(v - 3));
            steps.push_back(ZLO | GRA | RIN);
        end else if (v <= 14) begin
            steps.push_back(GRB | ROU | YIN);
            steps.push_back(CO | ZIN | alu(v == 12 ? 0 : (v == 13 ? 2 : 3)));
            steps.push_back(ZLO | GRA | RIN);
        end else if (v == 19) begin
            steps.push_back(GRA | ROU | CON);
            steps.push_back(PCO | YIN);
            steps.push_back(CO | ZIN | alu(0));
            steps.push_back(con ? (ZLO | PCI) : 29'd0);
        end else if (v == 22) begin
            steps.push_back(INP | GRA | RIN);
        end else if (v == 23) begin
            steps.push_back(GRA | ROU | OUP);
        end else if (v == 26) begin
            steps.push_back(29'd0);
        end else if (v == 27) begin
            steps.push_back(29'd0);
            halts = 1'b1;
        end else begin
            steps.push_back(ILL);
        end
        exp_q.delete();
        foreach (steps[i]) exp_q.push_back(steps[i] | RUN);
    endtask

    task automatic check(input string tag, input logic [28:0] expv);
        int drivers;
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
        drivers = $countones({PCout, MDRout, Rout, Zlowout, Cout, BAout, InPortout});
        n_cmp++;
        assert (drivers <= 1) else begin
            n_fail++;
            $error("FAIL %s_bus_excl: observed=%0d drivers expected<=1", tag, drivers);
        end
    endtask

    task automatic do_reset(input string tag);
        rst  = 1'b1;
        stop = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check(tag, RUN);
        rst = 1'b0;
    endtask

    // Runs one instruction from T0. abort_at >= 0 asserts rst after that step.
    // If it ends in HALT, checks hold_cycles of HALT and then resets.
    task automatic run_instr(input logic [4:0] opc, input bit con, input bit stop_req,
                             input int abort_at, input int hold_cycles, input string tag);
        bit halts;
        int n;
        build_model(opc, con, halts);
        n      = exp_q.size();
        opcode = opc;
        con_ff = con;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("%s_t%0d", tag, i), exp_q[i]);
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check($sformatf("%s_abort", tag), RUN);
                rst = 1'b0;
                return;
            end
            stop = (i == n - 1) ? stop_req : 1'b0;
        end
        if (halts || stop_req) begin
            for (int k = 0; k < hold_cycles; k++) begin
                @(posedge clk);
                @(negedge clk);
                stop = 1'b0;
                check($sformatf("%s_halt%0d", tag, k), 29'd0);
            end
            do_reset({tag, "_rst"});
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 5'd0;
        con_ff = 1'b0;
        stop   = 1'b0;
        do_reset("reset");

        run_instr(5'b00011, 1'b0, 1'b0, -1, 0, "add");
        run_instr(5'b00000, 1'b0, 1'b0, -1, 0, "ld");
        run_instr(5'b10011, 1'b1, 1'b0, -1, 0, "br_taken");
        run_instr(5'b10011, 1'b0, 1'b0, -1, 0, "br_not");
        run_instr(5'b01011, 1'b0, 1'b0, -1, 0, "shl");
        run_instr(5'b01101, 1'b0, 1'b0, -1, 0, "andi");
        run_instr(5'b10111, 1'b0, 1'b1, -1, 20, "out_stop");
        run_instr(5'b11110, 1'b0, 1'b0, -1, 0, "illegal");
        run_instr(5'b00010, 1'b0, 1'b0, 5, 0, "st_abort");
        run_instr(5'b00010, 1'b0, 1'b0, -1, 0, "st");
        run_instr(5'b11011, 1'b0, 1'b0, -1, 5, "halt");
        run_instr(5'b00001, 1'b0, 1'b1, -1, 3, "ldi_stop");

        for (int r = 0; r < 80; r++) begin
            logic [4:0] opc;
            bit         con;
            bit         stp;
            int         ab;
            opc = 5'($urandom_range(0, 31));
            if (opc == 5'b11011 && $urandom_range(0, 3) != 0) opc = 5'b11010;
            con = 1'($urandom_range(0, 1));
            stp = ($urandom_range(0, 9) == 0);
            ab  = ($urandom_range(0, 11) == 0) ? int'($urandom_range(0, 7)) : -1;
            run_instr(opc, con, stp, ab, 3, $sformatf("rnd%0d_op%0d", r, opc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
